binary_round_engine: RTL
========================

# binary_round_engine

Round engine for the binary game. It draws pseudo-random 8-bit targets, runs a per-round countdown, checks the switch value against the target on each submit, and keeps the session score and high score. It sits between the top-level debounced button pulses and the game display path: it consumes single-cycle pulses and `userNumber`, and produces the target number, score, timer and wrong-answer flag that the game FSM and the SSD/VGA path display.

## Interface
- `TICK_DIV`, 100_000_000: board_clk cycles per timer second; must be ≥2.
- `ROUND_SECS`, 10: seconds per round, 1..255.
- `ROUNDS`, 10: rounds per session, 1..255.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- `board_clk`  in  1  clock.
- `Reset_Pulse`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle pulse; begins a session.
- `submit`  in  1  single-cycle pulse; checks `userNumber` against the target.
- `quit`  in  1  single-cycle pulse; ends the session.
- `userNumber`  in  8  switch value, already registered upstream.
- `outputNumber`  out  8  current target.
- `playerScore`  out  8  correct answers in the current or last session.
- `highScore`  out  8  best `playerScore` since reset.
- `timeLeft`  out  8  seconds remaining in the round.
- `isWrong`  out  1  last submit was wrong, or the round timed out.
- `active`  out  1  high in LOAD or PLAY.
- `done`  out  1  high in DONE.

## Operation
- **States:** IDLE, LOAD, PLAY, DONE.
- **Reset values:**
  - state IDLE; LFSR `LFSR_SEED`.
  - all other outputs, the round counter and the tick counter are 0.
- **LFSR:**
  - 8-bit Fibonacci: `{q[6:0], q[7]^q[5]^q[4]^q[3]}`.
  - Advances every cycle in all states, including IDLE.
  - Never zero.
- **IDLE:**
  - `start` → LOAD; clear `playerScore`, round counter and `isWrong`.
  - `submit` and `quit` are ignored.
- **LOAD (one cycle):**
  - `outputNumber` ← LFSR.
  - `timeLeft` ← `ROUND_SECS`; tick counter ← 0; `isWrong` ← 0.
  - → PLAY. All pulses are ignored.
- **PLAY, tick counter:** counts 0..`TICK_DIV`-1 and wraps; on wrap, `timeLeft` decrements.
- **PLAY, event priority in one cycle:** quit > submit > timeout.
  - `quit` → DONE. Score is kept; the round is not counted.
  - `submit` with `userNumber == outputNumber`:
    - `playerScore` += 1, saturating at 255.
    - Round counter += 1.
    - → DONE if the new count equals `ROUNDS`, otherwise → LOAD.
  - `submit` with a mismatch: `isWrong` ← 1; stay in PLAY; no penalty; the timer keeps running.
  - Timeout (tick wrap while `timeLeft == 1`):
    - `timeLeft` ← 0; `isWrong` ← 1; round counter += 1; score unchanged.
    - → DONE or LOAD, by the same rule as a correct submit.
    - `isWrong` stays 1 through LOAD's clear only if the next state is DONE. In LOAD it is cleared.
  - A submit in the same cycle as the timeout wrap is evaluated as a submit; the timeout is discarded.
- **DONE:**
  - On entry edge: `highScore` ← max(`highScore`, final `playerScore`).
  - `outputNumber`, `playerScore` and `timeLeft` hold.
  - `start` → LOAD, with the same clears as from IDLE.
  - `quit` and `submit` are ignored.
- **Width rules:** all counters are unsigned. The round counter is 8-bit and compared for equality. The tick counter is sized `$clog2(TICK_DIV)`.

## Timing
- `start` at cycle N:
  - LOAD at edge N+1.
  - New `outputNumber` and `timeLeft` visible after edge N+2; PLAY from N+2.
- Correct `submit` at N:
  - `playerScore` updates at N+1.
  - Next target at N+2.
  - Last round: `done` = 1 at N+1 and `highScore` updates at N+1.
- Wrong `submit` at N: `isWrong` = 1 at N+1.
- Round length: timeout exit edge occurs exactly `ROUND_SECS*TICK_DIV` cycles after entering PLAY.
- `quit` at N: `done` = 1 at N+1.
- Outputs are registered; no combinational input-to-output paths.
- `Reset_Pulse` mid-session:
  - All state returns to reset values immediately, including `highScore` and the LFSR.
  - The first `start` is accepted on the first edge after deassertion.

## Test plan
- **Reset/idle:** assert `Reset_Pulse` mid-PLAY → every output 0, state IDLE; `submit` in IDLE → no change.
- **Correct sequence:** `TICK_DIV`=4, `ROUND_SECS`=3, `ROUNDS`=2, seed A5.
  - `start`, then submit `userNumber = outputNumber` twice.
  - Required: `playerScore` 1, then 2; `done`=1; `highScore`=2; second target differs from the first; the first target equals the LFSR value sampled at the LOAD edge.
- **Wrong then right:** submit `outputNumber ^ 8'h01` → `isWrong`=1, score 0, still PLAY; then correct submit → score 1, `isWrong`=0 after LOAD.
- **Timeout:** no submit.
  - `timeLeft` steps 3→2→1→0 at 4-cycle intervals.
  - At cycle 12 after PLAY entry: `isWrong`=1, round counted, next LOAD.
  - A second timeout → `done`=1, score 0, `highScore` unchanged.
- **Simultaneous events:**
  - `quit`+correct `submit` in one cycle → DONE, score unchanged.
  - Correct `submit` on the timeout-wrap cycle → score +1, no wrong flag.
- **Restart/high score:** session 1 scores 2; session 2 scores 1 → `highScore` stays 2, `playerScore` 1; `start` from DONE clears the score at +1 cycle.

Source files
------------

// File: rtl/binary_round_engine.sv
// Round engine for the binary game: LFSR targets, per-round countdown, answer checking and scoring.
// Consumes single-cycle button pulses; every output comes straight from a register.
module binary_round_engine #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned ROUND_SECS = 10,
    parameter int unsigned ROUNDS     = 10,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       board_clk,
    input  logic       Reset_Pulse,
    input  logic       start,
    input  logic       submit,
    input  logic       quit,
    input  logic [7:0] userNumber,
    output logic [7:0] outputNumber,
    output logic [7:0] playerScore,
    output logic [7:0] highScore,
    output logic [7:0] timeLeft,
    output logic       isWrong,
    output logic       active,
    output logic       done
);

    localparam int unsigned      TickW     = $clog2(TICK_DIV);
    localparam logic [TickW-1:0] TickMax   = TickW'(TICK_DIV - 1);
    localparam logic [7:0]       RoundSecs = 8'(ROUND_SECS);
    localparam logic [7:0]       Rounds    = 8'(ROUNDS);

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       score_q, score_d;
    logic [7:0]       high_q, high_d;
    logic [7:0]       time_q, time_d;
    logic [7:0]       round_q, round_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic             wrong_q, wrong_d;

    logic [7:0] round_next;
    logic [7:0] score_inc;
    logic       last_round;
    logic       tick_wrap;

    assign round_next = round_q + 8'd1;
    assign last_round = (round_next == Rounds);
    assign tick_wrap  = (tick_q == TickMax);
    assign score_inc  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        target_d = target_q;
        score_d  = score_q;
        high_d   = high_q;
        time_d   = time_q;
        round_d  = round_q;
        tick_d   = tick_q;
        wrong_d  = wrong_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    score_d = 8'd0;
                    round_d = 8'd0;
                    wrong_d = 1'b0;
                end
            end
            StLoad: begin
                target_d = lfsr_q;
                time_d   = RoundSecs;
                tick_d   = '0;
                wrong_d  = 1'b0;
                state_d  = StPlay;
            end
            StPlay: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap && time_q != 8'd0) begin
                    time_d = time_q - 8'd1;
                end
                // quit beats submit beats timeout; a submit on the wrap cycle hides the timeout
                if (quit) begin
                    state_d = StDone;
                end else if (submit) begin
                    if (userNumber == target_q) begin
                        score_d = score_inc;
                        round_d = round_next;
                        state_d = last_round ? StDone : StLoad;
                    end else begin
                        wrong_d = 1'b1;
                    end
                end else if (tick_wrap && time_q == 8'd1) begin
                    time_d  = 8'd0;
                    wrong_d = 1'b1;
                    round_d = round_next;
                    state_d = last_round ? StDone : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase

        // High score is folded in on the edge that enters DONE, using the final score.
        if (state_d == StDone && state_q != StDone && score_d > high_q) begin
            high_d = score_d;
        end
    end

    always_ff @(posedge board_clk or posedge Reset_Pulse) begin
        if (Reset_Pulse) begin
            state_q  <= StIdle;
            lfsr_q   <= LFSR_SEED;
            target_q <= 8'd0;
            score_q  <= 8'd0;
            high_q   <= 8'd0;
            time_q   <= 8'd0;
            round_q  <= 8'd0;
            tick_q   <= '0;
            wrong_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            score_q  <= score_d;
            high_q   <= high_d;
            time_q   <= time_d;
            round_q  <= round_d;
            tick_q   <= tick_d;
            wrong_q  <= wrong_d;
        end
    end

    assign outputNumber = target_q;
    assign playerScore  = score_q;
    assign highScore    = high_q;
    assign timeLeft     = time_q;
    assign isWrong      = wrong_q;
    assign active       = (state_q == StLoad) || (state_q == StPlay);
    assign done         = (state_q == StDone);

endmodule
